// File: rtl/dragonfang_pkg.sv
// rtl/dragonfang_pkg.sv - shared vector execution types and element shift helper
package dragonfang_pkg;

  localparam int VLEN = 64;

  typedef enum logic [1:0] {
    SHIFT_NONE = 2'd0,
    SHIFT_SLL  = 2'd1,
    SHIFT_SRL  = 2'd2,
    SHIFT_SRA  = 2'd3
  } shift_op_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'd0,
    SEW_16 = 2'd1,
    SEW_32 = 2'd2,
    SEW_64 = 2'd3
  } sew_t;

  typedef struct packed {
    shift_op_t shift_op;
    sew_t      sew;
  } execution_vector_t;

  // Caller pre-extends the element (sign for SRA, zero otherwise) and truncates the result.
  function automatic logic [63:0] shift_word(shift_op_t op, logic [63:0] data, logic [5:0] amt);
    case (op)
      SHIFT_SLL: return data << amt;
      SHIFT_SRL: return data >> amt;
      SHIFT_SRA: return $signed(data) >>> amt;
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/execution_vectors_pkg.sv
// rtl/execution_vectors_pkg.sv - named decoded execution vectors for every shift op and SEW
package execution_vectors_pkg;
  import dragonfang_pkg::*;

  localparam execution_vector_t vsll_64 = '{shift_op: SHIFT_SLL, sew: SEW_64};
  localparam execution_vector_t vsll_32 = '{shift_op: SHIFT_SLL, sew: SEW_32};
  localparam execution_vector_t vsll_16 = '{shift_op: SHIFT_SLL, sew: SEW_16};
  localparam execution_vector_t vsll_8  = '{shift_op: SHIFT_SLL, sew: SEW_8};
  localparam execution_vector_t vsrl_64 = '{shift_op: SHIFT_SRL, sew: SEW_64};
  localparam execution_vector_t vsrl_32 = '{shift_op: SHIFT_SRL, sew: SEW_32};
  localparam execution_vector_t vsrl_16 = '{shift_op: SHIFT_SRL, sew: SEW_16};
  localparam execution_vector_t vsrl_8  = '{shift_op: SHIFT_SRL, sew: SEW_8};
  localparam execution_vector_t vsra_64 = '{shift_op: SHIFT_SRA, sew: SEW_64};
  localparam execution_vector_t vsra_32 = '{shift_op: SHIFT_SRA, sew: SEW_32};
  localparam execution_vector_t vsra_16 = '{shift_op: SHIFT_SRA, sew: SEW_16};
  localparam execution_vector_t vsra_8  = '{shift_op: SHIFT_SRA, sew: SEW_8};

endpackage

// File: rtl/shift_lane_64.sv
// rtl/shift_lane_64.sv - combinational shifter for one 64-bit slice at every SEW
module shift_lane_64
  import dragonfang_pkg::*;
(
  input  execution_vector_t execution_vector,
  input  logic [63:0]       vs2,
  input  logic [63:0]       vs1,
  output logic [63:0]       vd
);

  logic [3:0][63:0] res;
  logic             unused_vs1_bits;

  // Every SEW is computed in parallel; sew only picks which result leaves the lane.
  for (genvar s = 0; s < 4; s++) begin : g_sew
    localparam int W  = 8 << s;
    localparam int AW = 3 + s;
    for (genvar e = 0; e < 64 / W; e++) begin : g_elem
      logic signed [W-1:0] elem;
      logic        [63:0]  ext;
      logic        [W-1:0] shifted;
      assign elem    = vs2[e*W +: W];
      assign ext     = (execution_vector.shift_op == SHIFT_SRA) ? 64'(elem) : 64'(vs2[e*W +: W]);
      assign shifted = W'(shift_word(execution_vector.shift_op, ext, 6'(vs1[e*W +: AW])));
      assign res[s][e*W +: W] = shifted;
    end
  end

  assign vd              = res[execution_vector.sew];
  assign unused_vs1_bits = ^vs1;

endmodule

// File: rtl/vec_shift_unit.sv
// rtl/vec_shift_unit.sv - VLEN-wide vector shifter with one registered result stage
module vec_shift_unit
  import dragonfang_pkg::*;
#(
  parameter int VLEN = dragonfang_pkg::VLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  execution_vector_t execution_vector,
  input  logic              valid_in,
  input  logic [VLEN-1:0]   vs2,
  input  logic [VLEN-1:0]   vs1,
  output logic [VLEN-1:0]   vd,
  output logic              valid_out
);

  localparam int LANES = VLEN / 64;

  logic [VLEN-1:0] lane_vd;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    shift_lane_64 u_lane (
      .execution_vector (execution_vector),
      .vs2              (vs2[l*64 +: 64]),
      .vs1              (vs1[l*64 +: 64]),
      .vd               (lane_vd[l*64 +: 64])
    );
  end

  // vd only loads on a valid op so it holds its value through idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vd        <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        vd <= lane_vd;
      end
    end
  end

endmodule

// File: tb/tb_vec_shift_unit.sv
// tb/tb_vec_shift_unit.sv - self-checking bench for vec_shift_unit
module tb_vec_shift_unit;
  import dragonfang_pkg::*;
  import execution_vectors_pkg::*;

  localparam int VL = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  execution_vector_t execution_vector;
  logic              valid_in;
  logic [VL-1:0]     vs2, vs1;
  logic [VL-1:0]     vd;
  logic              valid_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VL-1:0] exp_vd;

  execution_vector_t all_ev [12] = '{vsll_64, vsll_32, vsll_16, vsll_8,
                                     vsrl_64, vsrl_32, vsrl_16, vsrl_8,
                                     vsra_64, vsra_32, vsra_16, vsra_8};

  vec_shift_unit #(.VLEN(VL)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .execution_vector (execution_vector),
    .valid_in         (valid_in),
    .vs2              (vs2),
    .vs1              (vs1),
    .vd               (vd),
    .valid_out        (valid_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VL-1:0] got, input logic [VL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Element-by-element software model: extract, shift with integer arithmetic, reinsert.
  function automatic logic [VL-1:0] model(shift_op_t op, sew_t sew, logic [VL-1:0] a, logic [VL-1:0] b);
    logic [VL-1:0] r;
    logic [63:0]   mask, e, res;
    int            w, amt;
    r    = '0;
    w    = 8 << int'(sew);
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    if (op == SHIFT_NONE) return '0;
    for (int i = 0; i < VL / w; i++) begin
      e   = 64'(a >> (i * w)) & mask;
      amt = int'((64'(b >> (i * w)) & mask) % 64'(w));
      case (op)
        SHIFT_SLL: res = (e << amt) & mask;
        SHIFT_SRL: res = e >> amt;
        default: begin
          res = e >> amt;
          if (e[w-1]) res = res | (mask & ~(mask >> amt));
        end
      endcase
      r = r | (VL'(res) << (i * w));
    end
    return r;
  endfunction

  task automatic run_op(input execution_vector_t ev, input logic v, input logic [VL-1:0] a,
                        input logic [VL-1:0] b, input logic [VL-1:0] exp, input string tag);
    @(negedge clk);
    execution_vector = ev;
    valid_in         = v;
    vs2              = a;
    vs1              = b;
    @(posedge clk);
    #1;
    check(tag, vd, exp);
    check({tag, "_valid"}, VL'(valid_out), VL'(v));
  endtask

  initial begin
    rst_n            = 1'b0;
    valid_in         = 1'b1;
    execution_vector = vsll_64;
    vs2              = {$urandom, $urandom, $urandom, $urandom};
    vs1              = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_vd", vd, '0);
      check("reset_valid", VL'(valid_out), '0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(vsll_64, 1'b1, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFC5, 64'h20, "vsll_64_amt5");
    run_op(vsll_64, 1'b1, 64'h8000_0000_0000_0001, 64'h1, 64'h2, "vsll_64_carry");
    run_op(vsrl_32, 1'b1, 64'h8000_0000_F000_0000, 64'h0000_0004_0000_0024,
           64'h0800_0000_0F00_0000, "vsrl_32");
    run_op(vsra_16, 1'b1, 64'h8000_7FFF_F0F0_0F0F, 64'h000F_0001_0004_0014,
           64'hFFFF_3FFF_FF0F_00F0, "vsra_16");
    run_op(vsll_8, 1'b1, 64'h8181_8181_8181_8181, 64'h0706_0504_0302_0100,
           64'h8040_2010_0804_0281, "vsll_8");
    run_op(vsra_8, 1'b1, 64'h8181_8181_8181_8181, 64'h0706_0504_0302_0100,
           64'hFFFE_FCF8_F0E0_C081, "vsra_8");
    run_op('{shift_op: SHIFT_NONE, sew: SEW_32}, 1'b1, '1, '0, '0, "none_zero");
    run_op(vsra_64, 1'b1, {64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000},
           {64'h3F, 64'h0}, {64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000}, "vsra_64_max");
    exp_vd = vd;
    run_op(vsll_8, 1'b0, '1, '1, exp_vd, "idle_hold");

    exp_vd = '0;
    for (int i = 0; i < 400; i++) begin
      execution_vector_t ev;
      logic              v;
      logic [VL-1:0]     a, b;
      ev = all_ev[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) ev.shift_op = SHIFT_NONE;
      v  = ($urandom_range(0, 3) != 0);
      a  = {$urandom, $urandom, $urandom, $urandom};
      b  = {$urandom, $urandom, $urandom, $urandom};
      if (v) exp_vd = model(ev.shift_op, ev.sew, a, b);
      else   exp_vd = vd;
      run_op(ev, v, a, b, exp_vd, "random");
    end

    run_op(vsrl_16, 1'b1, '1, '0, '1, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_vd", vd, '0);
    check("async_reset_valid", VL'(valid_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(vsrl_64, 1'b1, {64'h10, 64'h10}, {64'h4, 64'h4}, {64'h1, 64'h1}, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
